rr_select_arbiter: RTL and testbench

- Round-robin arbiter that generates the select code for the n-way Mux stage directly downstream.
- Grants one of N requesters, holds a stable select code plus one-hot grant until the consumer accepts it, then rotates priority.
- Sits between per-source request lines and the Mux/Mux2 data-path select input.

---
 rtl/rr_arb_pkg.sv | 19 +
 rtl/rr_pick.sv | 28 ++
 rtl/rr_select_arbiter.sv | 95 +++++++++
 tb/tb_rr_select_arbiter.sv | 128 ++++++++++++
 4 files changed

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin select arbiter.
// Helpers work on 32-bit values; callers size-cast to their own widths.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  function automatic logic [31:0] onehot(input logic [31:0] sel);
    return 32'd1 << sel;
  endfunction

  function automatic logic [31:0] next_ptr(input logic [31:0] sel,
                                           input logic [31:0] nreq);
    return (sel + 32'd1) % nreq;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Wrap-around priority search: the first set req bit at or above ptr, modulo NREQ.
module rr_pick #(
  parameter int unsigned SWITCH_BITS = 2
) (
  input  logic [(1<<SWITCH_BITS)-1:0] req,
  input  logic [SWITCH_BITS-1:0]      ptr,
  output logic                        any,
  output logic [SWITCH_BITS-1:0]      pick
);

  localparam int unsigned NREQ = 1 << SWITCH_BITS;

  always_comb begin
    logic [SWITCH_BITS-1:0] idx;
    any  = 1'b0;
    pick = '0;
    idx  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      // NREQ is a power of two, so the index wraps by plain overflow.
      idx = ptr + SWITCH_BITS'(i);
      if (!any && req[idx]) begin
        any  = 1'b1;
        pick = idx;
      end
    end
  end

endmodule

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter producing a held select code and one-hot grant for a mux.
// Define RR_ARB_BACK_TO_BACK_EN to re-grant on the handshake edge (no idle bubble).
module rr_select_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned SWITCH_BITS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [(1<<SWITCH_BITS)-1:0] req,
  input  logic                        grant_ready,
  output logic                        grant_valid,
  output logic [SWITCH_BITS-1:0]      grant_sel,
  output logic [(1<<SWITCH_BITS)-1:0] grant_onehot
);

  localparam int unsigned NREQ = 1 << SWITCH_BITS;

  arb_state_e             state_q;
  logic [SWITCH_BITS-1:0] ptr_q, ptr_d;
  logic                   valid_q;
  logic [SWITCH_BITS-1:0] sel_q;
  logic [NREQ-1:0]        onehot_q;
  logic                   handshake;
  logic                   pick_any;
  logic [SWITCH_BITS-1:0] pick_sel;

  assign handshake = (state_q == GRANT) && grant_ready;

  // The search runs from the post-handshake pointer so a back-to-back grant
  // already sees the rotated priority.
  always_comb begin
    ptr_d = ptr_q;
    if (handshake) begin
      ptr_d = SWITCH_BITS'(next_ptr(32'(sel_q), 32'(NREQ)));
    end
  end

  rr_pick #(.SWITCH_BITS(SWITCH_BITS)) u_pick (
    .req (req),
    .ptr (ptr_d),
    .any (pick_any),
    .pick(pick_sel)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      sel_q    <= '0;
      onehot_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            state_q  <= GRANT;
            valid_q  <= 1'b1;
            sel_q    <= pick_sel;
            onehot_q <= NREQ'(onehot(32'(pick_sel)));
          end
        end
        GRANT: begin
          if (grant_ready) begin
`ifdef RR_ARB_BACK_TO_BACK_EN
            if (pick_any) begin
              sel_q    <= pick_sel;
              onehot_q <= NREQ'(onehot(32'(pick_sel)));
            end else begin
              state_q  <= IDLE;
              valid_q  <= 1'b0;
              onehot_q <= '0;
            end
`else
            state_q  <= IDLE;
            valid_q  <= 1'b0;
            onehot_q <= '0;
`endif
          end
        end
        default: begin
          state_q  <= IDLE;
          valid_q  <= 1'b0;
          onehot_q <= '0;
        end
      endcase
    end
  end

  assign grant_valid  = valid_q;
  assign grant_sel    = sel_q;
  assign grant_onehot = onehot_q;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Directed plus randomized checks of rr_select_arbiter against a behavioural model.
module tb_rr_select_arbiter;

  localparam int SB   = 2;
  localparam int NREQ = 1 << SB;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic            grant_ready = 1'b0;
  logic            grant_valid;
  logic [SB-1:0]   grant_sel;
  logic [NREQ-1:0] grant_onehot;

  int total = 0;
  int bad   = 0;

  // model state
  bit m_valid = 0;
  int m_sel   = 0;
  int m_ptr   = 0;

  rr_select_arbiter #(.SWITCH_BITS(SB)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant_ready (grant_ready),
    .grant_valid (grant_valid),
    .grant_sel   (grant_sel),
    .grant_onehot(grant_onehot)
  );

  always #5 clk = ~clk;

  function automatic int first_from(input int p, input logic [NREQ-1:0] r);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] r, input logic rdy, input logic rs);
    logic [NREQ-1:0] exp_oh;
    req = r;
    grant_ready = rdy;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      m_valid = 0; m_sel = 0; m_ptr = 0;
    end else if (!m_valid) begin
      if (r != 0) begin
        m_sel = first_from(m_ptr, r);
        m_valid = 1;
      end
    end else if (rdy) begin
      m_ptr = (m_sel + 1) % NREQ;
`ifdef RR_ARB_BACK_TO_BACK_EN
      if (r != 0) m_sel = first_from(m_ptr, r);
      else m_valid = 0;
`else
      m_valid = 0;
`endif
    end
    #1;
    exp_oh = m_valid ? NREQ'(1 << m_sel) : '0;
    chk("valid",  32'(grant_valid),  32'(m_valid));
    chk("sel",    32'(grant_sel),    32'(m_sel));
    chk("onehot", 32'(grant_onehot), 32'(exp_oh));
  endtask

  initial begin
    // reset and idle with no requests
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0000, 1'b0, 1'b1);
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_onehot", 32'(grant_onehot), 32'd0);
    for (int i = 0; i < 5; i++) step(4'b0000, 1'b1, 1'b0);

    // full load rotation
    for (int i = 0; i < 10; i++) step(4'b1111, 1'b1, 1'b0);

    // single requester held while consumer stalls
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0100, 1'b0, 1'b0);
    chk("hold_sel2", 32'(grant_sel), 32'd2);
    chk("hold_oh2", 32'(grant_onehot), 32'h4);
    for (int i = 0; i < 3; i++) step(4'b0000, 1'b0, 1'b0);
    chk("locked_sel2", 32'(grant_sel), 32'd2);
    chk("locked_valid", 32'(grant_valid), 32'd1);
    step(4'b0000, 1'b1, 1'b0);
    chk("accept_drop", 32'(grant_valid), 32'd0);

    // ptr=3: wrap search picks 0 then 2
    step(4'b0101, 1'b0, 1'b0);
    chk("wrap_sel0", 32'(grant_sel), 32'd0);
    step(4'b0101, 1'b1, 1'b0);
    step(4'b0101, 1'b0, 1'b0);
    chk("wrap_sel2", 32'(grant_sel), 32'd2);
    chk("wrap_oh2", 32'(grant_onehot), 32'h4);

    // reset mid-grant with ready high discards the handshake
    step(4'b0000, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b0);
    chk("pre_rst_sel1", 32'(grant_sel), 32'd1);
    step(4'b1111, 1'b1, 1'b1);
    chk("rst_mid_valid", 32'(grant_valid), 32'd0);
    step(4'b1111, 1'b0, 1'b0);
    chk("post_rst_sel0", 32'(grant_sel), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(NREQ'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
